cfa_mem_arbiter: RTL and testbench
==================================

CFA_MEM_ARBITER -- requirements
Module: cfa_mem_arbiter

Interface
REQ-001 The block SHALL have parameter addressBitWidth, default 17, memory word address width.
REQ-002 The block SHALL have parameter dataBitWidth, default 12, width of each colour channel.
REQ-003 The block SHALL have parameter fifoDepth, default 4, write-buffer entries (power of two, >=2).
REQ-004 The block SHALL have parameter starveMax, default 8, maximum consecutive read grants while writes are pending.
REQ-005 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-006 Port: rst  in  1  reset, synchronous, active-high.
REQ-007 Port: rdReq  in  1  demosaic engine requests a read this cycle.
REQ-008 Port: rdAddress  in  addressBitWidth  read address.
REQ-009 Port: rdGrant  out  1  read accepted this cycle (combinational).
REQ-010 Port: rdValid  out  1  rdGreen/rdRed/rdBlue valid (one cycle after grant).
REQ-011 Port: rdGreen, rdRed, rdBlue  out  dataBitWidth each  read data per channel.
REQ-012 Port: wrEnable  in  3  per-channel write request {blue,red,green}; any bit set = write request.
REQ-013 Port: wrAddress  in  addressBitWidth  write address.
REQ-014 Port: wrGreen, wrRed, wrBlue  in  dataBitWidth each  write data.
REQ-015 Port: frameEnd  in  1  one-cycle pulse: engine has issued its last write of the pass.
REQ-016 Port: flushDone  out  1  one-cycle pulse: all buffered writes committed.
REQ-017 Port: wrFull  out  1  write buffer holds fifoDepth entries.
REQ-018 Port: memAddress  out  addressBitWidth  single-port RAM address.
REQ-019 Port: memEn  out  1  RAM access this cycle.
REQ-020 Port: memWe  out  3  per-channel RAM write strobes {blue,red,green}.
REQ-021 Port: memWGreen, memWRed, memWBlue  out  dataBitWidth each  RAM write data.
REQ-022 Port: memRGreen, memRRed, memRBlue  in  dataBitWidth each  RAM read data, one-cycle latency.

Function
REQ-023 Memory side outputs SHALL be combinational from the arbitration decision; exactly one of {read, drain, none} is issued per cycle.
REQ-024 A write request (wrEnable!=0) SHALL be pushed into the write FIFO (address, data, strobes) every cycle it is presented; no handshake is required from the writer.
REQ-025 Arbitration priority per cycle: (1) drain if FIFO full; (2) drain if FIFO non-empty and starve counter == starveMax; (3) read if rdReq; (4) drain if FIFO non-empty; (5) idle.
REQ-026 rdGrant SHALL be 1 only when the read is issued; the engine SHALL hold rdReq/rdAddress until granted.
REQ-027 Drain SHALL drive memAddress/memW*/memWe from FIFO head, memEn=1, and pop the head.
REQ-028 Read SHALL drive memAddress=rdAddress, memEn=1, memWe=0; rdValid SHALL assert the next cycle with rd* = memR*.
REQ-029 Starve counter SHALL increment on each read grant while FIFO non-empty, clear on any drain or when FIFO empty, and saturate at starveMax.
REQ-030 Push and pop in the same cycle SHALL leave the count unchanged; push when full is accepted because rule (1) guarantees a pop that cycle.
REQ-031 FIFO pointers SHALL wrap modulo fifoDepth; count width log2(fifoDepth)+1.
REQ-032 wrFull SHALL equal (count == fifoDepth), registered-state derived, no combinational path from wrEnable.
REQ-033 State machine: RUN (default) -> FLUSH on frameEnd; FLUSH -> DONE when count==0 and no push this cycle; DONE -> RUN unconditionally after one cycle.
REQ-034 In FLUSH, drain SHALL take priority over reads whenever FIFO non-empty.
REQ-035 flushDone SHALL be 1 only in DONE (one cycle).
REQ-036 frameEnd arriving with an empty FIFO SHALL yield flushDone two cycles later (RUN->FLUSH->DONE).
REQ-037 frameEnd while already in FLUSH or DONE SHALL be ignored.

Reset
REQ-038 On rst: state=RUN, FIFO count and pointers=0, starve counter=0, rdValid=0, flushDone=0, rd* data registers=0.
REQ-039 rst mid-operation SHALL discard all buffered writes; memEn/memWe SHALL be 0 in the cycle rst is sampled high.

Verification
REQ-040 Reads only: rdReq=1 at addresses 0..9, no writes -> rdGrant=1 every cycle, rdValid follows by 1 cycle with RAM data of each address.
REQ-041 Writes only: 5 consecutive writes, wrEnable=3'b001 -> each drained next available cycle, memWe=3'b001, count never exceeds 1.
REQ-042 Starvation: rdReq held 1, one write pushed -> 8 read grants, then rdGrant=0 and one drain on cycle 9.
REQ-043 Full: rdReq=1 and 4 back-to-back writes while reads win -> wrFull=1, next cycle drain issued, rdGrant=0, fifth concurrent write accepted, count stays 4.
REQ-044 Flush: 3 entries buffered, frameEnd pulse with rdReq=1 -> 3 drains, rdGrant=0 meanwhile, flushDone pulses once, then reads resume.
REQ-045 Reset mid-flush: rst in FLUSH with 2 entries -> no writes issued after rst, flushDone never asserts, wrFull=0.

Source files
------------

// File: rtl/cfa_mem_arbiter_if.sv
// Bundle between the demosaic engine, the arbiter and the single-port RGB RAM.
// The arbiter takes the slave view; the engine/RAM side takes the master view.
interface cfa_mem_arbiter_if #(
  parameter int addressBitWidth = 17,
  parameter int dataBitWidth    = 12
);
  logic                       rdReq;
  logic [addressBitWidth-1:0] rdAddress;
  logic                       rdGrant;
  logic                       rdValid;
  logic [dataBitWidth-1:0]    rdGreen, rdRed, rdBlue;
  logic [2:0]                 wrEnable;
  logic [addressBitWidth-1:0] wrAddress;
  logic [dataBitWidth-1:0]    wrGreen, wrRed, wrBlue;
  logic                       frameEnd;
  logic                       flushDone;
  logic                       wrFull;
  logic [addressBitWidth-1:0] memAddress;
  logic                       memEn;
  logic [2:0]                 memWe;
  logic [dataBitWidth-1:0]    memWGreen, memWRed, memWBlue;
  logic [dataBitWidth-1:0]    memRGreen, memRRed, memRBlue;

  modport master (
    output rdReq, rdAddress, wrEnable, wrAddress, wrGreen, wrRed, wrBlue, frameEnd,
    output memRGreen, memRRed, memRBlue,
    input  rdGrant, rdValid, rdGreen, rdRed, rdBlue, flushDone, wrFull,
    input  memAddress, memEn, memWe, memWGreen, memWRed, memWBlue
  );

  modport slave (
    input  rdReq, rdAddress, wrEnable, wrAddress, wrGreen, wrRed, wrBlue, frameEnd,
    input  memRGreen, memRRed, memRBlue,
    output rdGrant, rdValid, rdGreen, rdRed, rdBlue, flushDone, wrFull,
    output memAddress, memEn, memWe, memWGreen, memWRed, memWBlue
  );
endinterface

// File: rtl/cfa_mem_arbiter.sv
// Arbitrates one single-port RGB RAM between engine reads and a posted write FIFO,
// with starvation protection for writes and an end-of-frame flush handshake.
module cfa_mem_arbiter #(
  parameter int addressBitWidth = 17,
  parameter int dataBitWidth    = 12,
  parameter int fifoDepth       = 4,
  parameter int starveMax       = 8
) (
  input logic              clk,
  input logic              rst,
  cfa_mem_arbiter_if.slave bus
);
  localparam int ptrW = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int cntW = ptrW + 1;
  localparam int stvW = $clog2(starveMax + 1);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
  state_t state;

  logic [addressBitWidth-1:0] fifoAddr  [fifoDepth];
  logic [dataBitWidth-1:0]    fifoGreen [fifoDepth];
  logic [dataBitWidth-1:0]    fifoRed   [fifoDepth];
  logic [dataBitWidth-1:0]    fifoBlue  [fifoDepth];
  logic [2:0]                 fifoWe    [fifoDepth];
  logic [ptrW-1:0]            wrPtr, rdPtr;
  logic [cntW-1:0]            count;
  logic [stvW-1:0]            starve;

  logic                    rdValid_p1;
  logic [dataBitWidth-1:0] rdGreenHold, rdRedHold, rdBlueHold;

  logic push, empty, full, doDrain, doRead;

  assign push  = |bus.wrEnable;
  assign empty = (count == '0);
  assign full  = (count == cntW'(fifoDepth));

  // Drain wins when forced (full, starved, flushing) or when nobody wants to read.
  assign doDrain = !rst && !empty &&
                   (full || (starve == stvW'(starveMax)) || (state == FLUSH) || !bus.rdReq);
  assign doRead  = !rst && bus.rdReq && !doDrain;

  assign bus.rdGrant    = doRead;
  assign bus.memEn      = doDrain | doRead;
  assign bus.memWe      = doDrain ? fifoWe[rdPtr] : 3'b000;
  assign bus.memAddress = doDrain ? fifoAddr[rdPtr] : bus.rdAddress;
  assign bus.memWGreen  = fifoGreen[rdPtr];
  assign bus.memWRed    = fifoRed[rdPtr];
  assign bus.memWBlue   = fifoBlue[rdPtr];
  assign bus.wrFull     = full;
  assign bus.flushDone  = (state == DONE);

  // Write capture: storage only, occupancy is tracked by the control block.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoAddr[wrPtr]  <= bus.wrAddress;
      fifoGreen[wrPtr] <= bus.wrGreen;
      fifoRed[wrPtr]   <= bus.wrRed;
      fifoBlue[wrPtr]  <= bus.wrBlue;
      fifoWe[wrPtr]    <= bus.wrEnable;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      starve     <= '0;
      state      <= RUN;
      rdValid_p1 <= 1'b0;
    end else begin
      if (push)    wrPtr <= wrPtr + 1'b1;
      if (doDrain) rdPtr <= rdPtr + 1'b1;
      case ({push, doDrain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (doDrain || empty)
        starve <= '0;
      else if (doRead && (starve != stvW'(starveMax)))
        starve <= starve + 1'b1;
      rdValid_p1 <= doRead;
      case (state)
        RUN:     if (bus.frameEnd) state <= FLUSH;
        FLUSH:   if (empty && !push) state <= DONE;
        default: state <= RUN;
      endcase
    end
  end

  // ---- stage p1: RAM data returns the cycle after the read grant ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rdGreenHold <= '0;
      rdRedHold   <= '0;
      rdBlueHold  <= '0;
    end else if (rdValid_p1) begin
      rdGreenHold <= bus.memRGreen;
      rdRedHold   <= bus.memRRed;
      rdBlueHold  <= bus.memRBlue;
    end
  end

  assign bus.rdValid = rdValid_p1;
  assign bus.rdGreen = rdValid_p1 ? bus.memRGreen : rdGreenHold;
  assign bus.rdRed   = rdValid_p1 ? bus.memRRed   : rdRedHold;
  assign bus.rdBlue  = rdValid_p1 ? bus.memRBlue  : rdBlueHold;
endmodule

// File: tb/tb_cfa_mem_arbiter.sv
// Bench for cfa_mem_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of the arbitration rules.
module tb_cfa_mem_arbiter;
  localparam int AW = 17, DW = 12, DEPTH = 4, SMAX = 8, MEMN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cfa_mem_arbiter_if #(.addressBitWidth(AW), .dataBitWidth(DW)) bus ();

  cfa_mem_arbiter #(.addressBitWidth(AW), .dataBitWidth(DW), .fifoDepth(DEPTH), .starveMax(SMAX))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // RAM seen by the DUT; contents start from a fixed pattern.
  logic [DW-1:0] ramG [MEMN];
  logic [DW-1:0] ramR [MEMN];
  logic [DW-1:0] ramB [MEMN];
  logic ramInit = 1'b0;

  always @(posedge clk) begin
    if (!ramInit) begin
      for (int i = 0; i < MEMN; i++) begin
        ramG[i] <= DW'(i * 37 + 5);
        ramR[i] <= DW'(i * 91 + 7);
        ramB[i] <= DW'(i * 13 + 200);
      end
      bus.memRGreen <= '0;
      bus.memRRed   <= '0;
      bus.memRBlue  <= '0;
      ramInit <= 1'b1;
    end else if (bus.memEn) begin
      if (bus.memWe[0]) ramG[bus.memAddress[5:0]] <= bus.memWGreen;
      if (bus.memWe[1]) ramR[bus.memAddress[5:0]] <= bus.memWRed;
      if (bus.memWe[2]) ramB[bus.memAddress[5:0]] <= bus.memWBlue;
      if (bus.memWe == 3'b000) begin
        bus.memRGreen <= ramG[bus.memAddress[5:0]];
        bus.memRRed   <= ramR[bus.memAddress[5:0]];
        bus.memRBlue  <= ramB[bus.memAddress[5:0]];
      end
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] g, r, b;
    logic [2:0]    we;
  } wr_t;

  wr_t q[$];
  int  starve = 0;
  int  mstate = 0;            // 0 = run, 1 = flushing, 2 = done
  bit  expValid = 0;
  logic [DW-1:0] expG = '0, expR = '0, expB = '0;
  logic [DW-1:0] refG [MEMN];
  logic [DW-1:0] refR [MEMN];
  logic [DW-1:0] refB [MEMN];
  bit  lastGrant;
  bit  obsGrant, obsDrain, obsFull, obsDone;
  int  vectors = 0, miscompares = 0;

  task automatic setIdle();
    bus.rdReq = 1'b0; bus.rdAddress = '0; bus.wrEnable = 3'b000; bus.wrAddress = '0;
    bus.wrGreen = '0; bus.wrRed = '0; bus.wrBlue = '0; bus.frameEnd = 1'b0;
  endtask

  task automatic setWrite(input int a, input logic [2:0] we);
    bus.wrEnable = we; bus.wrAddress = AW'(a);
    bus.wrGreen = DW'($urandom); bus.wrRed = DW'($urandom); bus.wrBlue = DW'($urandom);
  endtask

  // One clock: predict this cycle from the rules, compare, then advance the model.
  task automatic step();
    int n; bit full, drain, rd; wr_t h, e; logic [2:0] expWe;
    @(negedge clk);
    n = q.size(); full = (n == DEPTH);
    if (rst) begin drain = 0; rd = 0; end
    else begin
      drain = (n > 0) && (full || starve == SMAX || mstate == 1 || !bus.rdReq);
      rd = bus.rdReq && !drain;
    end
    expWe = drain ? q[0].we : 3'b000;
    vectors++; if (bus.rdGrant !== rd) begin miscompares++; $display("FAIL rdGrant got %b exp %b t=%0t", bus.rdGrant, rd, $time); end
    vectors++; if (bus.memEn !== (drain || rd)) begin miscompares++; $display("FAIL memEn got %b exp %b t=%0t", bus.memEn, drain || rd, $time); end
    vectors++; if (bus.memWe !== expWe) begin miscompares++; $display("FAIL memWe got %b exp %b t=%0t", bus.memWe, expWe, $time); end
    if (drain) begin
      vectors++;
      if (bus.memAddress !== q[0].addr || {bus.memWGreen, bus.memWRed, bus.memWBlue} !== {q[0].g, q[0].r, q[0].b}) begin
        miscompares++;
        $display("FAIL drainWord got %h/%h%h%h exp %h/%h%h%h t=%0t", bus.memAddress, bus.memWGreen, bus.memWRed, bus.memWBlue,
                 q[0].addr, q[0].g, q[0].r, q[0].b, $time);
      end
    end else if (rd) begin
      vectors++; if (bus.memAddress !== bus.rdAddress) begin miscompares++; $display("FAIL readAddress got %h exp %h t=%0t", bus.memAddress, bus.rdAddress, $time); end
    end
    vectors++; if (bus.wrFull !== full) begin miscompares++; $display("FAIL wrFull got %b exp %b t=%0t", bus.wrFull, full, $time); end
    vectors++; if (bus.flushDone !== (mstate == 2)) begin miscompares++; $display("FAIL flushDone got %b exp %b t=%0t", bus.flushDone, mstate == 2, $time); end
    vectors++; if (bus.rdValid !== expValid) begin miscompares++; $display("FAIL rdValid got %b exp %b t=%0t", bus.rdValid, expValid, $time); end
    if (expValid) begin
      vectors++;
      if ({bus.rdGreen, bus.rdRed, bus.rdBlue} !== {expG, expR, expB}) begin
        miscompares++;
        $display("FAIL readData got %h%h%h exp %h%h%h t=%0t", bus.rdGreen, bus.rdRed, bus.rdBlue, expG, expR, expB, $time);
      end
    end
    lastGrant = rd;
    obsGrant = bus.rdGrant; obsDrain = bus.memEn && (bus.memWe != 3'b000);
    obsFull = bus.wrFull; obsDone = bus.flushDone;
    @(posedge clk);
    if (rst) begin
      q.delete(); starve = 0; mstate = 0; expValid = 0;
    end else begin
      if (drain) begin
        h = q.pop_front();
        if (h.we[0]) refG[h.addr[5:0]] = h.g;
        if (h.we[1]) refR[h.addr[5:0]] = h.r;
        if (h.we[2]) refB[h.addr[5:0]] = h.b;
      end
      expValid = rd;
      if (rd) begin
        expG = refG[bus.rdAddress[5:0]]; expR = refR[bus.rdAddress[5:0]]; expB = refB[bus.rdAddress[5:0]];
      end
      if (bus.wrEnable != 3'b000) begin
        e.addr = bus.wrAddress; e.g = bus.wrGreen; e.r = bus.wrRed; e.b = bus.wrBlue; e.we = bus.wrEnable;
        q.push_back(e);
      end
      if (drain || n == 0) starve = 0;
      else if (rd && starve < SMAX) starve++;
      case (mstate)
        0: if (bus.frameEnd) mstate = 1;
        1: if (n == 0 && bus.wrEnable == 3'b000) mstate = 2;
        default: mstate = 0;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; setIdle(); bus.rdReq = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step(); step();
    rst = 1'b0; bus.rdReq = 1'b0;
    vectors++; if (bus.rdValid !== 1'b0) begin miscompares++; $display("FAIL reset_rdValid got %b exp 0", bus.rdValid); end
    vectors++; if (bus.flushDone !== 1'b0) begin miscompares++; $display("FAIL reset_flushDone got %b exp 0", bus.flushDone); end
    vectors++; if (bus.wrFull !== 1'b0) begin miscompares++; $display("FAIL reset_wrFull got %b exp 0", bus.wrFull); end
    vectors++; if ({bus.rdGreen, bus.rdRed, bus.rdBlue} !== '0) begin miscompares++; $display("FAIL reset_rdData got %h%h%h exp 0", bus.rdGreen, bus.rdRed, bus.rdBlue); end
  endtask

  task automatic test_reads();
    int grants = 0;
    for (int i = 0; i < 10; i++) begin
      bus.rdReq = 1'b1; bus.rdAddress = AW'(i);
      step();
      if (obsGrant) grants++;
    end
    setIdle(); step();
    vectors++; if (grants !== 10) begin miscompares++; $display("FAIL reads_grants got %0d exp 10", grants); end
  endtask

  task automatic test_writes();
    int drains = 0;
    for (int i = 0; i < 5; i++) begin
      setWrite(10 + i, 3'b001); step();
      if (obsDrain) drains++;
      vectors++; if (obsFull !== 1'b0) begin miscompares++; $display("FAIL writes_full got %b exp 0", obsFull); end
    end
    setIdle(); step();
    if (obsDrain) drains++;
    vectors++; if (drains !== 5) begin miscompares++; $display("FAIL writes_drains got %0d exp 5", drains); end
  endtask

  task automatic test_starve();
    int grants = 0; bit drained = 0;
    bus.rdReq = 1'b1; bus.rdAddress = AW'(20);
    setWrite(21, 3'b111); step();
    bus.wrEnable = 3'b000;
    for (int k = 0; k < 12 && !drained; k++) begin
      step();
      if (obsDrain) drained = 1;
      else if (obsGrant) grants++;
    end
    vectors++; if (grants !== SMAX || !drained) begin miscompares++; $display("FAIL starve_grants got %0d drained %0d exp %0d drained 1", grants, drained, SMAX); end
    step(); setIdle(); step();
  endtask

  task automatic test_full();
    bus.rdReq = 1'b1; bus.rdAddress = AW'(30);
    for (int i = 0; i < 4; i++) begin setWrite(40 + i, 3'b010); step(); end
    setWrite(44, 3'b100); step();
    vectors++; if (!(obsFull && obsDrain && !obsGrant)) begin miscompares++; $display("FAIL full_cycle got full %b drain %b grant %b exp 1 1 0", obsFull, obsDrain, obsGrant); end
    bus.wrEnable = 3'b000; step();
    vectors++; if (obsFull !== 1'b1) begin miscompares++; $display("FAIL full_hold got %b exp 1", obsFull); end
    setIdle(); repeat (5) step();
  endtask

  task automatic test_flush();
    int drains = 0, pulses = 0, badGrant = 0, lateGrant = 0;
    bus.rdReq = 1'b1; bus.rdAddress = AW'(50);
    for (int i = 0; i < 3; i++) begin setWrite(51 + i, 3'(1 + (i % 7))); step(); end
    bus.wrEnable = 3'b000; bus.frameEnd = 1'b1; step(); bus.frameEnd = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.frameEnd = (k == 4);
      step();
      if (obsDrain) drains++;
      if (obsDone) pulses++;
      if (obsGrant && drains < 3) badGrant++;
      if (obsGrant && pulses > 0) lateGrant++;
    end
    setIdle();
    vectors++; if (drains !== 3) begin miscompares++; $display("FAIL flush_drains got %0d exp 3", drains); end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL flush_pulses got %0d exp 1", pulses); end
    vectors++; if (badGrant !== 0) begin miscompares++; $display("FAIL flush_readDuringDrain got %0d exp 0", badGrant); end
    vectors++; if (lateGrant == 0) begin miscompares++; $display("FAIL flush_readsResume got %0d exp >0", lateGrant); end
  endtask

  task automatic test_flush_empty();
    bit d0, d1, d2;
    setIdle(); bus.frameEnd = 1'b1; step(); d0 = obsDone;
    bus.frameEnd = 1'b0; step(); d1 = obsDone;
    step(); d2 = obsDone;
    step();
    vectors++; if ({d0, d1, d2} !== 3'b001) begin miscompares++; $display("FAIL flushEmpty_timing got %b exp 001", {d0, d1, d2}); end
  endtask

  task automatic test_reset_flush();
    int bad = 0;
    bus.rdReq = 1'b1; bus.rdAddress = AW'(55);
    for (int i = 0; i < 2; i++) begin setWrite(56 + i, 3'b111); step(); end
    bus.wrEnable = 3'b000; bus.frameEnd = 1'b1; step(); bus.frameEnd = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    vectors++; if (obsDrain || obsGrant) begin miscompares++; $display("FAIL rstFlush_accessInReset got drain %b grant %b exp 0 0", obsDrain, obsGrant); end
    setIdle();
    for (int k = 0; k < 6; k++) begin
      step();
      if (obsDrain || obsDone || obsFull) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rstFlush_after got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_random();
    setIdle();
    for (int k = 0; k < 400; k++) begin
      if (!bus.rdReq && $urandom_range(1, 0) == 1) begin bus.rdReq = 1'b1; bus.rdAddress = AW'($urandom_range(MEMN - 1, 0)); end
      if ($urandom_range(2, 0) == 0) setWrite($urandom_range(MEMN - 1, 0), 3'($urandom_range(7, 1)));
      else bus.wrEnable = 3'b000;
      bus.frameEnd = ($urandom_range(39, 0) == 0);
      step();
      if (lastGrant) bus.rdReq = 1'b0;
    end
    setIdle(); repeat (8) step();
  endtask

  initial begin
    for (int i = 0; i < MEMN; i++) begin
      refG[i] = DW'(i * 37 + 5); refR[i] = DW'(i * 91 + 7); refB[i] = DW'(i * 13 + 200);
    end
    setIdle();
    test_reset();
    test_reads();
    test_writes();
    test_starve();
    test_full();
    test_flush();
    test_flush_empty();
    test_reset_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
